// File: rtl/univ_reg.sv
// -----------------------------------------------------------------------------
// univ_reg
//   Parametrised universal register. It holds WIDTH bits and gives an
//   eight-mode datapath stage: hold, parallel load, shift left/right with
//   serial in, rotate left/right, and increment/decrement. It also has a
//   registered carry/borrow/shift-out flag and a zero indicator.
//
//   Priority on each rising edge: reset > preset > (en && mode op) > hold.
//
// Parameters
//   WIDTH      : register width in bits, 2..64
//   RESET_VAL  : value loaded by reset
//   PRESET_VAL : value loaded by preset
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (q <= RESET_VAL, co <= 0)
//   preset in   synchronous active-high preset (q <= PRESET_VAL, co <= 0)
//   en     in   clock enable for mode operations
//   mode   in   [2:0] operation select
//   d      in   [WIDTH-1:0] parallel load data
//   sin_l  in   serial in for shift-right (enters MSB)
//   sin_r  in   serial in for shift-left (enters LSB)
//   q      out  [WIDTH-1:0] register contents
//   co     out  registered carry/borrow/shift-out of the last operation
//   zero   out  combinational, 1 when q == 0
// -----------------------------------------------------------------------------
module univ_reg #(
  parameter int                 WIDTH      = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL  = '0,
  parameter logic [WIDTH-1:0]   PRESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             zero
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  // Catch illegal widths at elaboration rather than building a broken shifter.
  generate
    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
      $error("univ_reg: WIDTH must be in 2..64");
    end
  endgenerate

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             co_reg;
  logic             co_next;

  // Candidate results for every mode. They are computed in parallel and
  // then picked by mode.
  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] rol_val;
  logic [WIDTH-1:0] ror_val;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   dec_diff;

  // Per-bit neighbour wiring for the shift and rotate paths. The end bits
  // take the serial input (shift) or the opposite end bit (rotate).
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign shl_val[gi] = sin_r;
        assign rol_val[gi] = q_reg[WIDTH-1];
      end else begin : g_lsb_n
        assign shl_val[gi] = q_reg[gi-1];
        assign rol_val[gi] = q_reg[gi-1];
      end

      if (gi == WIDTH-1) begin : g_msb
        assign shr_val[gi] = sin_l;
        assign ror_val[gi] = q_reg[0];
      end else begin : g_msb_n
        assign shr_val[gi] = q_reg[gi+1];
        assign ror_val[gi] = q_reg[gi+1];
      end
    end
  endgenerate

  // Arithmetic is done one bit wider than the register. The extra bit is the
  // carry out of INC. For DEC the extra bit is set only when 0 - 1 wraps,
  // so it already reads as the borrow.
  assign inc_sum  = {1'b0, q_reg} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_diff = {1'b0, q_reg} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    q_next  = q_reg;
    co_next = co_reg;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          q_next  = q_reg;
          co_next = 1'b0;
        end
        MODE_LOAD: begin
          q_next  = d;
          co_next = 1'b0;
        end
        MODE_SHL: begin
          q_next  = shl_val;
          co_next = q_reg[WIDTH-1];
        end
        MODE_SHR: begin
          q_next  = shr_val;
          co_next = q_reg[0];
        end
        MODE_ROL: begin
          q_next  = rol_val;
          co_next = q_reg[WIDTH-1];
        end
        MODE_ROR: begin
          q_next  = ror_val;
          co_next = q_reg[0];
        end
        MODE_INC: begin
          q_next  = inc_sum[WIDTH-1:0];
          co_next = inc_sum[WIDTH];
        end
        MODE_DEC: begin
          q_next  = dec_diff[WIDTH-1:0];
          co_next = dec_diff[WIDTH];
        end
        default: begin
          q_next  = q_reg;
          co_next = co_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg  <= RESET_VAL;
      co_reg <= 1'b0;
    end else if (preset) begin
      q_reg  <= PRESET_VAL;
      co_reg <= 1'b0;
    end else begin
      q_reg  <= q_next;
      co_reg <= co_next;
    end
  end

  assign q    = q_reg;
  assign co   = co_reg;
  assign zero = (q_reg == '0);

endmodule

// File: tb/tb_univ_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_reg
//   Self-checking bench for univ_reg (WIDTH=8, default reset/preset values).
//   A behavioural model tracks the expected q/co with plain integer
//   arithmetic. One compare process checks q, co and zero against the model
//   on every falling edge once the model is valid. Directed sequences add
//   hand-computed literal checks, and a randomized run follows them.
// -----------------------------------------------------------------------------
module tb_univ_reg;

  localparam int W = 8;
  localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

  logic         clk = 1'b0;
  logic         reset, preset, en, sin_l, sin_r;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         co, zero;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state
  longint unsigned m_q = 0;
  bit              m_co = 1'b0;
  bit              m_valid = 1'b0;

  univ_reg #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .preset(preset), .en(en), .mode(mode),
    .d(d), .sin_l(sin_l), .sin_r(sin_r), .q(q), .co(co), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected outcome of one edge, worked out from the operation rules.
  task automatic model_edge(input bit r, input bit p, input bit e, input int md,
                            input longint unsigned dv, input bit sl, input bit sr);
    longint unsigned old;
    old = m_q;
    if (r) begin
      m_q = 0; m_co = 0; m_valid = 1'b1;
    end else if (p) begin
      m_q = MASK; m_co = 0;
    end else if (e) begin
      case (md)
        0: begin m_co = 0; end
        1: begin m_q = dv & MASK; m_co = 0; end
        2: begin m_q = ((old << 1) | sr) & MASK;             m_co = (old >> (W-1)) & 1; end
        3: begin m_q = (old >> 1) | (longint'(sl) << (W-1)); m_co = old & 1; end
        4: begin m_q = ((old << 1) | (old >> (W-1))) & MASK; m_co = (old >> (W-1)) & 1; end
        5: begin m_q = (old >> 1) | ((old & 1) << (W-1));    m_co = old & 1; end
        6: begin m_q = (old + 1) % (MASK + 1); m_co = (old == MASK); end
        default: begin m_q = (old + MASK) % (MASK + 1); m_co = (old == 0); end
      endcase
    end
  endtask

  // Drive one edge: set the inputs, let the posedge happen, update the model,
  // then wait for the falling edge where the compare process samples.
  task automatic step(input bit r, input bit p, input bit e, input int md,
                      input longint unsigned dv, input bit sl, input bit sr);
    reset = r; preset = p; en = e; mode = 3'(md); d = W'(dv); sin_l = sl; sin_r = sr;
    @(posedge clk);
    model_edge(r, p, e, md, dv, sl, sr);
    @(negedge clk);
  endtask

  task automatic op(input int md, input longint unsigned dv, input bit sl, input bit sr);
    step(1'b0, 1'b0, 1'b1, md, dv, sl, sr);
  endtask

  // Compare process: every falling edge once the model is valid.
  always @(negedge clk) begin
    if (m_valid) begin
      check("q_vs_model", q, m_q);
      check("co_vs_model", co, m_co);
      check("zero_vs_model", zero, (m_q == 0));
    end
  end

  initial begin
    reset = 0; preset = 0; en = 0; mode = 0; d = 0; sin_l = 0; sin_r = 0;
    @(negedge clk);

    // Reset / preset / both high
    step(1, 0, 0, 0, 0, 0, 0);
    check("reset_q", q, 8'h00); check("reset_co", co, 0); check("reset_zero", zero, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    check("preset_q", q, 8'hFF); check("preset_co", co, 0); check("preset_zero", zero, 0);
    step(1, 1, 1, 1, 8'h55, 0, 0);
    check("reset_wins_q", q, 8'h00);

    // LOAD, SHL, SHR
    op(1, 8'hA5, 0, 0); check("load_q", q, 8'hA5);
    op(2, 0, 0, 1);     check("shl_q", q, 8'h4B); check("shl_co", co, 1);
    op(3, 0, 0, 0);     check("shr_q", q, 8'h25); check("shr_co", co, 1);

    // LOAD, ROL, ROR, ROR
    op(1, 8'h81, 0, 0);
    op(4, 0, 0, 0);     check("rol_q", q, 8'h03); check("rol_co", co, 1);
    op(5, 0, 0, 0);     check("ror1_q", q, 8'h81); check("ror1_co", co, 1);
    op(5, 0, 0, 0);     check("ror2_q", q, 8'hC0); check("ror2_co", co, 1);

    // Increment wrap and decrement borrow
    op(1, 8'hFE, 0, 0);
    op(6, 0, 0, 0);     check("inc1_q", q, 8'hFF); check("inc1_co", co, 0);
    op(6, 0, 0, 0);     check("inc2_q", q, 8'h00); check("inc2_co", co, 1); check("inc2_zero", zero, 1);
    op(7, 0, 0, 0);     check("dec_q", q, 8'hFF); check("dec_co", co, 1);

    // Enable low holds q and co, then HOLD clears co
    op(1, 8'h10, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 6, 8'hEE, 1, 1);
      check("en_low_q", q, 8'h10); check("en_low_co", co, 0);
    end
    op(7, 0, 0, 0); op(6, 0, 0, 0);  // leaves co=0, q=0x10 after dec/inc
    op(0, 0, 0, 0);     check("hold_q", q, 8'h10); check("hold_co", co, 0);

    // Count run interrupted by reset on the third edge
    step(1, 0, 0, 0, 0, 0, 0);
    op(6, 0, 0, 0);     check("run1_q", q, 8'h01);
    op(6, 0, 0, 0);     check("run2_q", q, 8'h02);
    step(1, 0, 1, 6, 0, 0, 0); check("run3_q", q, 8'h00);
    op(6, 0, 0, 0);     check("run4_q", q, 8'h01);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
           longint'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
